// File: rtl/tlc_pkg.sv
// Shared types and helpers for the traffic light controller family.
// Holds lamp codes, the phase enumeration and the direction-index width helper.
package tlc_pkg;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  typedef enum logic [1:0] {
    PH_ALL_RED = 2'b00,
    PH_GREEN   = 2'b01,
    PH_YELLOW  = 2'b10
  } phase_t;

  // Width of a direction index; never narrower than one bit.
  function automatic int dir_width(input int num_dirs);
    return (num_dirs <= 2) ? 1 : $clog2(num_dirs);
  endfunction

  // Lamp code shown by the active approach in a given phase.
  function automatic logic [1:0] lamp_for_phase(input phase_t ph);
    case (ph)
      PH_GREEN:  return LAMP_GREEN;
      PH_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/tlc_rr_select.sv
// Combinational round-robin picker: finds the first set request after the
// current index, wrapping, with the current index itself considered last.
// When nothing is requested, found is low and next_idx echoes cur_idx.
module tlc_rr_select
  import tlc_pkg::*;
#(
  parameter int NUM_DIRS = 2,
  parameter int DW       = dir_width(NUM_DIRS)
) (
  input  logic [NUM_DIRS-1:0] pending,
  input  logic [DW-1:0]       cur_idx,
  output logic [DW-1:0]       next_idx,
  output logic                found
);

  logic [DW-1:0] scan_idx;

  // Scan the request vector starting one past the current index.
  always_comb begin
    next_idx = cur_idx;
    found    = 1'b0;
    scan_idx = '0;
    for (int off = 1; off <= NUM_DIRS; off++) begin
      scan_idx = DW'((int'(cur_idx) + off) % NUM_DIRS);
      if (!found && pending[scan_idx]) begin
        found    = 1'b1;
        next_idx = scan_idx;
      end
    end
  end

endmodule

// File: rtl/traffic_light_controller_n.sv
// Demand-actuated N-approach traffic light controller.
// Each approach in turn runs GREEN -> YELLOW -> ALL_RED; green length adapts
// between GREEN_MIN and GREEN_MAX depending on latched calls from others.
// Optional emergency preemption is compiled in with `define TLC_PREEMPT_EN.
module traffic_light_controller_n
  import tlc_pkg::*;
#(
  parameter int NUM_DIRS      = 2,
  parameter int GREEN_MIN     = 4,
  parameter int GREEN_MAX     = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int DW            = dir_width(NUM_DIRS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_DIRS-1:0]   demand,
`ifdef TLC_PREEMPT_EN
  input  logic                  preempt_req,
  input  logic [DW-1:0]         preempt_dir,
`endif
  output logic [2*NUM_DIRS-1:0] lights,
  output logic [DW-1:0]         active_dir,
  output logic [1:0]            phase,
  output logic [NUM_DIRS-1:0]   pending
);

  localparam int CNT_MAX_GY = (GREEN_MAX > YELLOW_CYCLES) ? GREEN_MAX : YELLOW_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_GY > ALLRED_CYCLES) ? CNT_MAX_GY : ALLRED_CYCLES;
  localparam int CW         = $clog2(CNT_MAX + 1);

  phase_t                phase_q, phase_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         active_dir_q, active_dir_d;
  logic [NUM_DIRS-1:0]   pending_q, pending_d;
  logic [2*NUM_DIRS-1:0] lights_q, lights_d;

  logic [DW-1:0]         rr_next;
  logic                  rr_found;
  logic [DW-1:0]         next_dir;
  logic                  others_pending;
  logic                  end_green;
  logic                  hold_green;
  int                    cycle_k;
`ifdef TLC_PREEMPT_EN
  logic                  preempt_valid;
`endif

  tlc_rr_select #(
    .NUM_DIRS (NUM_DIRS),
    .DW       (DW)
  ) u_rr_select (
    .pending  (pending_q),
    .cur_idx  (active_dir_q),
    .next_idx (rr_next),
    .found    (rr_found)
  );

  // Next-state logic: call latching, phase timing and next-approach choice.
  always_comb begin
    phase_d        = phase_q;
    cnt_d          = cnt_q + CW'(1);
    active_dir_d   = active_dir_q;
    pending_d      = pending_q;
    lights_d       = '0;
    cycle_k        = int'(cnt_q) + 1;
    others_pending = 1'b0;
    end_green      = 1'b0;
    hold_green     = 1'b0;
    next_dir       = rr_next;

    // Latch calls; the approach currently showing green does not call itself.
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (pending_q[i] && (i != int'(active_dir_q))) begin
        others_pending = 1'b1;
      end
      if (demand[i] && !((phase_q == PH_GREEN) && (i == int'(active_dir_q)))) begin
        pending_d[i] = 1'b1;
      end
    end

    // Fall back to plain rotation when nobody is calling.
    if (!rr_found) begin
      if (active_dir_q >= DW'(NUM_DIRS - 1)) begin
        next_dir = '0;
      end else begin
        next_dir = active_dir_q + DW'(1);
      end
    end

    end_green = ((cycle_k >= GREEN_MIN) && others_pending) || (cycle_k >= GREEN_MAX);

`ifdef TLC_PREEMPT_EN
    preempt_valid = preempt_req && (int'(preempt_dir) < NUM_DIRS);
    if (preempt_valid) begin
      next_dir = preempt_dir;
      if (preempt_dir == active_dir_q) begin
        hold_green = 1'b1;
        end_green  = 1'b0;
      end else begin
        end_green  = 1'b1;
      end
    end
`endif

    case (phase_q)
      PH_GREEN: begin
        if (hold_green) begin
          cnt_d = '0;
        end else if (end_green) begin
          phase_d = PH_YELLOW;
          cnt_d   = '0;
        end
      end
      PH_YELLOW: begin
        if (cycle_k >= YELLOW_CYCLES) begin
          phase_d = PH_ALL_RED;
          cnt_d   = '0;
        end
      end
      PH_ALL_RED: begin
        if (cycle_k >= ALLRED_CYCLES) begin
          phase_d             = PH_GREEN;
          cnt_d               = '0;
          active_dir_d        = next_dir;
          pending_d[next_dir] = 1'b0;
        end
      end
      default: begin
        phase_d = PH_ALL_RED;
        cnt_d   = '0;
      end
    endcase

    // Only the approach being served shows anything other than red.
    for (int i = 0; i < NUM_DIRS; i++) begin
      if (i == int'(active_dir_d)) begin
        lights_d[2*i +: 2] = lamp_for_phase(phase_d);
      end else begin
        lights_d[2*i +: 2] = LAMP_RED;
      end
    end
  end

  // State and registered outputs; reset drops straight to all-red.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PH_ALL_RED;
      cnt_q        <= '0;
      active_dir_q <= DW'(NUM_DIRS - 1);
      pending_q    <= '0;
      lights_q     <= '0;
    end else begin
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      active_dir_q <= active_dir_d;
      pending_q    <= pending_d;
      lights_q     <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign active_dir = active_dir_q;
  assign phase      = phase_q;
  assign pending    = pending_q;

endmodule
